// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Widths match the decoder's 12-bit AddrImm field and 16-bit instruction word.
package instr_fetch_pkg;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC = 12'h000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory req/ack bus between the fetch stage (master) and memory (slave).
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic               MemReq;
  logic [ADDR_W-1:0]  MemAddr;
  logic               MemAck;
  logic [INSTR_W-1:0] MemData;

  modport master (output MemReq, MemAddr, input MemAck, MemData);
  modport slave  (input MemReq, MemAddr, output MemAck, MemData);

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, req/ack fetch from instruction memory, one-deep hold
// buffer for downstream stall, and redirect with squash of an in-flight request.
//
// state | meaning
// IDLE  | no request outstanding; waits for Run
// REQ   | request outstanding at mem_addr_q; may carry a pending squash
// HOLD  | fetched word parked in the hold buffer until Stall drops
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_ADDR = RESET_PC
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               Run,
  input  logic               Stall,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  Target,
  instr_fetch_if.master      mem,
  output logic [INSTR_W-1:0] Instr,
  output logic               InstrValid,
  output logic [ADDR_W-1:0]  InstrPC
);

  state_e             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               mem_req_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [INSTR_W-1:0] instr_q;
  logic               instr_valid_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic               squash_q;
  logic [ADDR_W-1:0]  squash_pc_q;
  logic [INSTR_W-1:0] hold_data_q;
  logic [ADDR_W-1:0]  hold_pc_q;

  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  redir_pc;

  assign pc_inc   = pc_q + 1'b1;
  // A live Redirect on the ack cycle overrides any previously latched target.
  assign redir_pc = Redirect ? Target : squash_pc_q;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q       <= IDLE;
      pc_q          <= RESET_ADDR;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= RESET_ADDR;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= '0;
      squash_q      <= 1'b0;
      squash_pc_q   <= '0;
      hold_data_q   <= '0;
      hold_pc_q     <= '0;
    end else begin
      instr_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Redirect) pc_q <= Target;
          if (Run) begin
            state_q    <= REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= Redirect ? Target : pc_q;
          end
        end
        REQ: begin
          if (mem.MemAck) begin
            if (Redirect || squash_q) begin
              squash_q   <= 1'b0;
              pc_q       <= redir_pc;
              state_q    <= Run ? REQ : IDLE;
              mem_req_q  <= Run;
              mem_addr_q <= redir_pc;
            end else if (Stall) begin
              hold_data_q <= mem.MemData;
              hold_pc_q   <= pc_q;
              pc_q        <= pc_inc;
              state_q     <= HOLD;
              mem_req_q   <= 1'b0;
            end else begin
              instr_q       <= mem.MemData;
              instr_pc_q    <= pc_q;
              instr_valid_q <= 1'b1;
              pc_q          <= pc_inc;
              state_q       <= Run ? REQ : IDLE;
              mem_req_q     <= Run;
              mem_addr_q    <= pc_inc;
            end
          end else if (Redirect) begin
            // Address must stay put until the ack; remember where to go afterwards.
            squash_q    <= 1'b1;
            squash_pc_q <= Target;
          end
        end
        HOLD: begin
          if (Redirect) begin
            pc_q       <= Target;
            state_q    <= Run ? REQ : IDLE;
            mem_req_q  <= Run;
            mem_addr_q <= Target;
          end else if (!Stall) begin
            instr_q       <= hold_data_q;
            instr_pc_q    <= hold_pc_q;
            instr_valid_q <= 1'b1;
            state_q       <= Run ? REQ : IDLE;
            mem_req_q     <= Run;
            mem_addr_q    <= pc_q;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem.MemReq  = mem_req_q;
  assign mem.MemAddr = mem_addr_q;
  assign Instr       = instr_q;
  assign InstrValid  = instr_valid_q;
  assign InstrPC     = instr_pc_q;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage. It sits directly upstream of the instruction decoder.
- Maintains the 12-bit program counter and fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Presents each fetched word on Instr with a one-cycle InstrValid strobe. InstrValid drives the decoder's EN input.
- Supports stall from downstream, redirect (jump/branch to a 12-bit target) and run/halt.

Parameters:
- ADDR_W, 12, program counter and memory address width; matches the decoder's 12-bit AddrImm field.
- INSTR_W, 16, instruction width.
- RESET_PC, 12'h000, PC value loaded at reset.

Ports:
- CLK in 1: single clock; all state updates on posedge.
- RSTn in 1: reset, synchronous, active-low.
- Run in 1: 1 = fetching permitted; 0 = finish any outstanding request, then idle.
- Stall in 1: 1 = downstream cannot accept an instruction this cycle.
- Redirect in 1: one-cycle request to continue fetching at Target.
- Target in ADDR_W: redirect destination.
- MemReq out 1: fetch request to instruction memory.
- MemAddr out ADDR_W: fetch address; stable while MemReq=1 and MemAck=0.
- MemAck in 1: memory completes the request this cycle; may be high in the same cycle MemReq rises.
- MemData in INSTR_W: instruction word; valid only when MemAck=1.
- Instr out INSTR_W: fetched instruction; holds its last value between strobes.
- InstrValid out 1: one-cycle strobe, Instr valid; connects to the decoder EN.
- InstrPC out ADDR_W: address of the word currently on Instr.

Behaviour:
- Registered outputs: all outputs are registered.
- Reset (RSTn=0 at posedge), values:
  - state=IDLE, PC=RESET_PC
  - MemReq=0, MemAddr=RESET_PC
  - Instr=0, InstrValid=0, InstrPC=0
  - pending-redirect flag cleared, hold buffer empty
- Reset mid-request drops the request. Memory must tolerate MemReq falling without an ack.
- States: IDLE, REQ, HOLD.
- IDLE:
  - MemReq=0.
  - Run=1: next cycle enter REQ with MemReq=1, MemAddr=PC.
- REQ:
  - MemReq=1, MemAddr=PC held stable.
  - MemAck=1, Stall=0, no squash: next cycle Instr=MemData, InstrValid=1, InstrPC=PC, PC=PC+1.
    - If Run=1, stay in REQ with MemAddr=PC+1 (back-to-back, one instr/cycle max).
    - Otherwise enter IDLE.
  - MemAck=1, Stall=1: capture MemData/PC into hold buffer, PC=PC+1, enter HOLD. InstrValid=0.
  - MemAck=0: remain in REQ, no outputs change.
- HOLD:
  - MemReq=0; the buffer is one deep, so no new request is issued.
  - Stall=0: next cycle present the buffer (InstrValid=1). Enter REQ if Run=1, else IDLE.
- InstrValid timing:
  - Never high two cycles for the same word.
  - Never high in any cycle where Stall was 1 at the preceding edge.
  - Latency from MemAck (Stall=0) to InstrValid is exactly 1 cycle.
- Redirect (highest priority over all other events in the same cycle):
  - IDLE: PC=Target.
  - HOLD: discard the buffer, PC=Target, go REQ if Run=1.
  - REQ, no ack this cycle: the address cannot change mid-handshake. Latch Target, set squash. When the ack arrives, drop MemData (no InstrValid), PC=Target, issue the new request next cycle.
  - REQ with MemAck in the same cycle: drop the returned word, PC=Target, REQ at Target next cycle.
  - A second Redirect while squash is pending overwrites the latched Target.
- Run=0:
  - Checked only when deciding to issue a new request.
  - An outstanding request always completes (delivered or buffered).
- Arithmetic: PC increment is modulo 2^ADDR_W; 12'hFFF wraps to 12'h000, no flag.
- Simultaneous Stall=1 and Redirect=1 in HOLD: Redirect wins, the buffer is discarded.

Decomposition:
- Package instr_fetch_pkg holds:
  - state enum (IDLE, REQ, HOLD)
  - ADDR_W/INSTR_W defaults
  - RESET_PC constant
- Single module. The PC/redirect logic and the one-entry hold buffer are too small to justify sub-modules.

Test Plan:
- Reset:
  - Stimulus: RSTn=0 for 2 cycles, Run=1, then release.
  - Response: MemReq=0, InstrValid=0, PC=000 during reset; MemReq=1, MemAddr=000 the cycle after release.
- Streaming:
  - Stimulus: memory acks same cycle with data 16'h1000+addr, Stall=0.
  - Response: InstrValid high every cycle; Instr=1000,1001,1002; InstrPC=000,001,002.
- Stall:
  - Stimulus: ack at addr 005 with Stall=1 for 3 cycles, then 0.
  - Response: InstrValid=0 during stall, MemReq=0 in HOLD; 1 cycle after Stall falls, Instr=1005, InstrPC=005, InstrValid=1; next MemAddr=006.
- Redirect with slow memory:
  - Stimulus: ack delay 3 cycles; Redirect Target=12'h0A0 one cycle after MemReq at 010.
  - Response: MemAddr stays 010 until ack; that word dropped (no InstrValid); next MemAddr=0A0; first delivered InstrPC=0A0.
- Wrap-around:
  - Stimulus: Redirect to FFE, streaming.
  - Response: InstrPC sequence FFE, FFF, 000, 001.
- Run drop / reset mid-op:
  - Stimulus: Run=0 while a request is outstanding.
  - Response: the word is still delivered once, then MemReq stays 0.
  - Stimulus: RSTn=0 while in HOLD.
  - Response: buffer discarded, no InstrValid, PC=000.
